// File: rtl/onflight_ctrl.sv
// rtl/onflight_ctrl.sv - in-order dual-lane FIFO controller for the 32 x 256-bit on-flight SRAM
//
// Purpose: owns all occupancy state (write/read pointers, count, sticky error)
// for an external pure-storage SRAM with one shared write enable, two write
// ports and two combinational read ports. Up to two lines enter and up to two
// lines retire per cycle, strictly in order.
//
// Ports:
//   clock, reset_n            single clock, synchronous active-low reset
//   in_valid1/2, in_data1/2   producer lanes (lane 2 only with lane 1)
//   in_ready                  at least two free entries
//   out_valid1/2, out_data1/2 two oldest lines presented to the consumer
//   out_pop1/2                consumer retires oldest / second-oldest
//   count, err                occupancy and sticky protocol-violation flag
//   sram_*                    SRAM write enable, write/read addresses and data
module onflight_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 256
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid1,
  input  logic [DW-1:0] in_data1,
  input  logic          in_valid2,
  input  logic [DW-1:0] in_data2,
  output logic          in_ready,
  output logic          out_valid1,
  output logic [DW-1:0] out_data1,
  output logic          out_valid2,
  output logic [DW-1:0] out_data2,
  input  logic          out_pop1,
  input  logic          out_pop2,
  output logic [AW:0]   count,
  output logic          err,
  output logic          sram_we,
  output logic [AW-1:0] sram_waddr1,
  output logic [AW-1:0] sram_waddr2,
  output logic [DW-1:0] sram_wdata1,
  output logic [DW-1:0] sram_wdata2,
  output logic [AW-1:0] sram_raddr1,
  output logic [AW-1:0] sram_raddr2,
  input  logic [DW-1:0] sram_rdata1,
  input  logic [DW-1:0] sram_rdata2
);

  localparam logic [AW:0]   LP_READY_MAX = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0]   LP_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LP_CNT_TWO   = (AW+1)'(2);
  localparam logic [AW-1:0] LP_PTR_ONE   = AW'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_err;

  logic          w_ready;
  logic          w_push1;
  logic          w_push2;
  logic          w_pop1;
  logic          w_pop2;
  logic [1:0]    w_push_cnt;
  logic [1:0]    w_pop_cnt;
  logic          w_viol;

  // Ready looks only at registered count, so no input-to-ready path exists.
  // Two free slots are demanded even for a single-lane push.
  assign w_ready = (r_count <= LP_READY_MAX);

  assign w_push1 = in_valid1 & w_ready;
  assign w_push2 = w_push1 & in_valid2;
  assign w_pop1  = out_pop1 & (r_count >= LP_CNT_ONE);
  assign w_pop2  = w_pop1 & out_pop2 & (r_count >= LP_CNT_TWO);

  assign w_push_cnt = {1'b0, w_push1} + {1'b0, w_push2};
  assign w_pop_cnt  = {1'b0, w_pop1} + {1'b0, w_pop2};

  // Lane-2 without lane-1, pop-2 without pop-1, or pops beyond occupancy.
  assign w_viol = (in_valid2 & ~in_valid1)
                | (out_pop2 & ~out_pop1)
                | (out_pop1 & (r_count < LP_CNT_ONE))
                | (out_pop2 & (r_count < LP_CNT_TWO));

  // The SRAM has one write enable, so port 2 always writes too; on a
  // single push it mirrors port 1 exactly to make the double write benign.
  assign sram_we     = w_push1;
  assign sram_waddr1 = r_wr_ptr;
  assign sram_wdata1 = in_data1;
  assign sram_waddr2 = w_push2 ? (r_wr_ptr + LP_PTR_ONE) : r_wr_ptr;
  assign sram_wdata2 = w_push2 ? in_data2 : in_data1;

  assign sram_raddr1 = r_rd_ptr;
  assign sram_raddr2 = r_rd_ptr + LP_PTR_ONE;
  assign out_data1   = sram_rdata1;
  assign out_data2   = sram_rdata2;

  assign in_ready   = w_ready;
  assign out_valid1 = (r_count >= LP_CNT_ONE);
  assign out_valid2 = (r_count >= LP_CNT_TWO);
  assign count      = r_count;
  assign err        = r_err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_cnt);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_cnt);
      r_count  <= r_count + (AW+1)'(w_push_cnt) - (AW+1)'(w_pop_cnt);
      if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/onflight_ctrl.md
# onflight_ctrl

In-order dual-lane FIFO controller that owns the 32-entry x 256-bit on-flight SRAM and sits directly upstream of it. It accepts up to two 256-bit lines per cycle from the producer and drives the SRAM's shared write enable and both write ports. It drives both read addresses so the two oldest lines are always presented to the consumer, and it retires up to two lines per cycle. It holds all occupancy state (pointers, count) so the SRAM stays a pure storage array.

## Interface

- DEPTH, 32, number of SRAM entries (power of two)
- AW, 5, address width, log2(DEPTH)
- DW, 256, line width
- clock  in  1  single clock, all state updates on posedge
- reset_n  in  1  reset, synchronous, active-low
- in_valid1  in  1  producer lane 1 line valid
- in_data1  in  DW  lane 1 line
- in_valid2  in  1  producer lane 2 line valid (only meaningful with in_valid1)
- in_data2  in  DW  lane 2 line
- in_ready  out  1  at least 2 free entries; push accepted only when high
- out_valid1  out  1  oldest entry present (count >= 1)
- out_data1  out  DW  oldest entry (= sram_rdata1)
- out_valid2  out  1  second-oldest present (count >= 2)
- out_data2  out  DW  second-oldest entry (= sram_rdata2)
- out_pop1  in  1  consumer retires oldest
- out_pop2  in  1  consumer retires second-oldest (only with out_pop1)
- count  out  AW+1  current occupancy, 0..DEPTH
- err  out  1  sticky protocol-violation flag
- sram_we  out  1  shared write enable to SRAM
- sram_waddr1, sram_waddr2  out  AW  SRAM write addresses
- sram_wdata1, sram_wdata2  out  DW  SRAM write data
- sram_raddr1, sram_raddr2  out  AW  SRAM read addresses
- sram_rdata1, sram_rdata2  in  DW  SRAM read data (combinational, ~0.5 ns)

## Operation

- State: wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0], err. Pointers wrap modulo DEPTH.
- Push qualification: push1 = in_valid1 & in_ready; push2 = push1 & in_valid2.
- in_valid2 without in_valid1: nothing is written and err is set.
- Write drive (combinational): sram_we = push1; sram_waddr1 = wr_ptr; sram_wdata1 = in_data1.
  - If push2: sram_waddr2 = wr_ptr+1, sram_wdata2 = in_data2.
  - Otherwise sram_waddr2 = sram_waddr1 and sram_wdata2 = sram_wdata1. The SRAM has a single WE, so both ports always write; they must carry the same address and data.
- Read drive: sram_raddr1 = rd_ptr; sram_raddr2 = rd_ptr+1 (wrapping); out_data1/2 pass sram_rdata1/2 through.
- Pop qualification: pop1 = out_pop1 & (count >= 1); pop2 = pop1 & out_pop2 & (count >= 2).
  - out_pop2 without out_pop1 sets err.
  - Any pop on an empty or too-short queue sets err; excess pops are dropped, so there is no underflow.
- Update: wr_ptr += push1+push2; rd_ptr += pop1+pop2; count += (push1+push2) - (pop1+pop2). Compute at AW+1 bits; the result never exceeds DEPTH or goes below 0.
- in_ready = (count <= DEPTH-2). This holds even if only one lane would be pushed.
- Simultaneous push and pop in one cycle are both applied. A pop never sees data pushed in the same cycle, because the SRAM write lands at that edge.
- err stays set until reset.

## Timing

- Reset (reset_n low at posedge): wr_ptr=0, rd_ptr=0, count=0, err=0. Then in_ready=1, out_valid1/2=0, sram_we=0.
- SRAM contents are not cleared. After reset, stale lines are unreachable because count=0.
- Reset mid-operation discards all entries on that edge. A push in the same cycle is not retained.
- Push-to-visible latency is 1 cycle. A line accepted at edge N is in the SRAM at edge N and appears on out_data1 with out_valid1 in cycle N+1, after the SRAM read delay.
- Pop takes effect at the edge. The next entries appear the following cycle.
- Full: count=31 or 32 drops in_ready. With count=30, a dual push reaches 32 (full) and a single push reaches 31.
- Wrap: with wr_ptr=31, a dual push writes addresses 31 and 0, and wr_ptr becomes 1. With rd_ptr=31, sram_raddr2=0.
- in_ready, out_valid* and count depend only on registered state. They carry no combinational path from in_* or out_pop*.

## Test plan

- Reset, then single push of 0xA5.. with no pop. Cycle after: out_valid1=1, out_data1=0xA5.., count=1, sram_waddr1=sram_waddr2=0 during the push cycle.
- 16 dual pushes (32 lines, values 0..31). count=32, in_ready=0 from count 31 onward. Then 16 dual pops return 0..31 in order; count=0, out_valid1=0.
- Pointer wrap: 30 single push/pop pairs to move the pointers to 30. Then dual push, dual push (writes 30,31 then 0,1). Pops return the same order; sram_raddr2=0 when rd_ptr=31.
- Simultaneous dual push and dual pop at count=2 for 10 cycles. count stays 2, in_ready stays 1, data order preserved.
- Protocol errors: in_valid2 alone with count=0 leaves sram_we=0 and sets err=1. out_pop1+out_pop2 with count=1 retires one line, count=0, err=1. err holds until reset.
- Assert reset_n low at count=20 while pushing. Next cycle count=0, out_valid1=0, in_ready=1, err=0. A subsequent push reads back correctly from address 0.
